// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, IDLE -> ACCESS -> RESP, big-endian byte lanes.
// Misaligned requests skip the memory access and report adel_o/ades_o with badvaddr_o.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] badvaddr_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [2:0] {
        OP_LB  = 3'b000, OP_LBU = 3'b001, OP_LH = 3'b010, OP_LHU = 3'b011,
        OP_LW  = 3'b100, OP_SB  = 3'b101, OP_SH = 3'b110, OP_SW  = 3'b111
    } op_t;

    state_t            state;
    op_t               op_q;
    op_t               op_in;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              in_store;
    logic              in_misaligned;
    logic              q_store;
    logic              access_active;
    logic [3:0]        sel;
    logic [31:0]       store_data;
    logic [31:0]       load_data;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;

    assign op_in = op_t'(op_i);

    always_comb begin
        in_store      = op_in inside {OP_SB, OP_SH, OP_SW};
        in_misaligned = 1'b0;
        case (op_in)
            OP_LH, OP_LHU, OP_SH: in_misaligned = addr_i[0];
            OP_LW, OP_SW:         in_misaligned = (addr_i[1:0] != 2'b00);
            default:              in_misaligned = 1'b0;
        endcase
    end

    assign q_store = op_q inside {OP_SB, OP_SH, OP_SW};

    // Lane 3 (sel[3], bits 31:24) holds the lowest byte address.
    always_comb begin
        sel        = 4'b1111;
        store_data = '0;
        case (op_q)
            OP_SB: begin
                sel        = 4'b1000 >> addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            OP_SH: begin
                sel        = addr_q[1] ? 4'b0011 : 4'b1100;
                store_data = {2{wdata_q[15:0]}};
            end
            OP_SW: begin
                sel        = 4'b1111;
                store_data = wdata_q;
            end
            default: begin
                sel        = 4'b1111;
                store_data = '0;
            end
        endcase
    end

    always_comb begin
        load_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: load_byte = mem_data_i[31:24];
            2'd1: load_byte = mem_data_i[23:16];
            2'd2: load_byte = mem_data_i[15:8];
            2'd3: load_byte = mem_data_i[7:0];
            default: load_byte = 8'h00;
        endcase
        load_half = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
        case (op_q)
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'h000000, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'h0000, load_half};
            default: load_data = mem_data_i;
        endcase
    end

    // Memory strobes decode straight from state so reset or flush drops them without a clock.
    assign access_active = (state == ACCESS);
    assign mem_ce_o      = access_active && !flush_i;
    assign mem_we_o      = access_active && q_store && !flush_i;
    assign mem_addr_o    = access_active ? addr_q : '0;
    assign mem_sel_o     = access_active ? sel : '0;
    assign mem_data_o    = access_active ? store_data : '0;
    assign ready_o       = (state == IDLE);
    assign done_o        = (state == RESP) && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= OP_LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_o    <= '0;
            adel_o     <= 1'b0;
            ades_o     <= 1'b0;
            badvaddr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && !flush_i) begin
                        op_q    <= op_in;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        if (in_misaligned) begin
                            state      <= RESP;
                            adel_o     <= !in_store;
                            ades_o     <= in_store;
                            badvaddr_o <= addr_i;
                            rdata_o    <= '0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        state   <= RESP;
                        rdata_o <= q_store ? 32'h0 : load_data;
                        adel_o  <= 1'b0;
                        ades_o  <= 1'b0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small big-endian byte-lane RAM model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [0:63];

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .flush_i(flush_i), .ready_o(ready_o), .done_o(done_o),
        .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    assign mem_data_i = ram[mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (mem_ce_o && mem_we_o) begin
            if (mem_sel_o[3]) ram[mem_addr_o[7:2]][31:24] <= mem_data_o[31:24];
            if (mem_sel_o[2]) ram[mem_addr_o[7:2]][23:16] <= mem_data_o[23:16];
            if (mem_sel_o[1]) ram[mem_addr_o[7:2]][15:8]  <= mem_data_o[15:8];
            if (mem_sel_o[0]) ram[mem_addr_o[7:2]][7:0]   <= mem_data_o[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request one step after a rising edge; returns one step after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        req_i   = 1'b1;
        op_i    = op;
        addr_i  = addr;
        wdata_i = wd;
        @(posedge clk); #1;
        req_i   = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] exp);
        issue(op, addr, 32'h0);
        chk({tag, "_ce"}, {31'h0, mem_ce_o}, 32'h1);
        chk({tag, "_we"}, {31'h0, mem_we_o}, 32'h0);
        chk({tag, "_sel"}, {28'h0, mem_sel_o}, 32'hF);
        chk({tag, "_addr"}, mem_addr_o, addr);
        chk({tag, "_busy"}, {30'h0, ready_o, done_o}, 32'h0);
        @(posedge clk); #1;
        chk({tag, "_done"}, {31'h0, done_o}, 32'h1);
        chk({tag, "_rdata"}, rdata_o, exp);
        chk({tag, "_err"}, {30'h0, adel_o, ades_o}, 32'h0);
        chk({tag, "_resp_ce"}, {31'h0, mem_ce_o}, 32'h0);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'h0, ready_o, done_o}, 32'h2);
        chk({tag, "_hold"}, rdata_o, exp);
    endtask

    task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] esel, input logic [31:0] edata);
        issue(op, addr, wd);
        chk({tag, "_ce_we"}, {30'h0, mem_ce_o, mem_we_o}, 32'h3);
        chk({tag, "_sel"}, {28'h0, mem_sel_o}, {28'h0, esel});
        chk({tag, "_data"}, mem_data_o, edata);
        @(posedge clk); #1;
        chk({tag, "_done"}, {31'h0, done_o}, 32'h1);
        chk({tag, "_err"}, {30'h0, adel_o, ades_o}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[4]  = 32'h8899AABB;
        rst     = 1'b1;
        req_i   = 1'b0;
        op_i    = 3'b000;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_done", {30'h0, ready_o, done_o}, 32'h2);
        chk("rst_err", {30'h0, adel_o, ades_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_badvaddr", badvaddr_o, 32'h0);
        chk("rst_mem", {mem_ce_o, mem_we_o, mem_sel_o}, 32'h0);
        chk("rst_mem_bus", mem_addr_o | mem_data_o, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_load("lb_11", 3'b000, 32'h11, 32'hFFFFFF99);
        do_load("lhu_12", 3'b011, 32'h12, 32'h0000AABB);
        do_load("lh_10", 3'b010, 32'h10, 32'hFFFF8899);
        do_load("lw_10", 3'b100, 32'h10, 32'h8899AABB);
        do_load("lbu_12", 3'b001, 32'h12, 32'h000000AA);

        do_store("sb_13", 3'b101, 32'h13, 32'h12345677, 4'b0001, 32'h77777777);
        do_load("lw_after_sb", 3'b100, 32'h10, 32'h8899AA77);
        do_store("sh_10", 3'b110, 32'h10, 32'h0000CAFE, 4'b1100, 32'hCAFECAFE);
        do_store("sb_11", 3'b101, 32'h11, 32'h000000F1, 4'b0100, 32'hF1F1F1F1);
        do_load("lw_after_sh", 3'b100, 32'h10, 32'hCAF1AA77);
        do_load("lb_13", 3'b000, 32'h13, 32'h00000077);
        do_store("sw_20", 3'b111, 32'h20, 32'h01020304, 4'b1111, 32'h01020304);
        do_store("sh_22", 3'b110, 32'h22, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF);
        do_load("lw_20", 3'b100, 32'h20, 32'h0102BEEF);

        issue(3'b100, 32'h16, 32'h0);
        chk("adel_ce", {31'h0, mem_ce_o}, 32'h0);
        chk("adel_done", {31'h0, done_o}, 32'h1);
        chk("adel_flags", {30'h0, adel_o, ades_o}, 32'h2);
        chk("adel_badvaddr", badvaddr_o, 32'h16);
        chk("adel_rdata", rdata_o, 32'h0);
        @(posedge clk); #1;
        chk("adel_idle", {30'h0, ready_o, done_o}, 32'h2);

        issue(3'b110, 32'h21, 32'h5555);
        chk("ades_ce", {30'h0, mem_ce_o, mem_we_o}, 32'h0);
        chk("ades_done", {31'h0, done_o}, 32'h1);
        chk("ades_flags", {30'h0, adel_o, ades_o}, 32'h1);
        chk("ades_badvaddr", badvaddr_o, 32'h21);
        @(posedge clk); #1;
        chk("ades_hold", badvaddr_o, 32'h21);

        flush_i = 1'b1;
        issue(3'b100, 32'h10, 32'h0);
        chk("flush_idle_block", {30'h0, ready_o, mem_ce_o}, 32'h2);
        flush_i = 1'b0;

        issue(3'b111, 32'h10, 32'hDEADBEEF);
        chk("flush_pre_we", {31'h0, mem_we_o}, 32'h1);
        flush_i = 1'b1;
        #1;
        chk("flush_ce_we", {30'h0, mem_ce_o, mem_we_o}, 32'h0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_after", {30'h0, ready_o, done_o}, 32'h2);
        @(posedge clk); #1;
        chk("flush_no_done", {31'h0, done_o}, 32'h0);
        do_load("lw_after_flush", 3'b100, 32'h10, 32'hCAF1AA77);

        issue(3'b111, 32'h10, 32'h11111111);
        chk("rst_mid_pre_we", {31'h0, mem_we_o}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_mem", {mem_ce_o, mem_we_o, mem_sel_o}, 32'h0);
        chk("rst_mid_state", {30'h0, ready_o, done_o}, 32'h2);
        chk("rst_mid_rdata", rdata_o, 32'h0);
        chk("rst_mid_badvaddr", badvaddr_o, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_after", {30'h0, ready_o, done_o}, 32'h2);
        do_load("lw_after_rst", 3'b100, 32'h10, 32'hCAF1AA77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
